// File: rtl/add_mul_seq.sv
// -----------------------------------------------------------------------------
// add_mul_seq
//   Multi-cycle 32x32 -> 64-bit unsigned shift-add multiplier. One 32-bit
//   ripple adder (module `add`, carry-in tied low) is exercised once per clock
//   while the sequencer walks the multiplier bits LSB first.
//
//   Handshake: `start` is accepted in IDLE or in the DONE cycle; `busy` is high
//   while steps run; `done` pulses for one cycle with `p` valid. `p` holds the
//   last product until the next accepted `start`.
//
//   Optional build macro: MUL_EARLY_EXIT_EN
//     When defined, the step count is latched on accept as the index of the
//     highest set bit of `b` plus one (1 when `b` is zero). The final step
//     realigns the partial product so `p` matches the full 32-step result.
//     Ports and reset values are identical in both builds.
//
//   The ripple adder `add` is included at the bottom of this file.
// -----------------------------------------------------------------------------
module add_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] p
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic [31:0] mc_r;
    logic [63:0] prod_r;
    logic [5:0]  cnt_r;
    logic        busy_r;
    logic        done_r;

    logic        accept_s;
    logic        step_en_s;
    logic        last_s;
    logic [5:0]  n_cur_s;

    logic [31:0] add_x_s;
    logic [31:0] add_y_s;
    logic [31:0] sum_s;
    logic        cout_s;
    logic [63:0] step_raw_s;
    logic [63:0] step_s;

`ifdef MUL_EARLY_EXIT_EN
    logic [5:0]  n_r;

    // Step count for a given multiplier: highest set bit index + 1, minimum 1.
    function automatic logic [5:0] steps_for(input logic [31:0] v);
        logic [5:0] r;
        r = 6'd1;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                r = i[5:0] + 6'd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    assign n_cur_s = n_r;
`else
    assign n_cur_s = 6'd32;
`endif

    // Adder operands: upper half of the partial product plus the multiplicand
    // gated by the current multiplier bit.
    assign add_x_s = prod_r[63:32];
    assign add_y_s = prod_r[0] ? mc_r : 32'd0;

    add u_add (
        .a    (add_x_s),
        .b    (add_y_s),
        .cin  (1'b0),
        .s    (sum_s),
        .cout (cout_s)
    );

    // One step keeps the adder carry as the new MSB and shifts the low half.
    assign step_raw_s = {cout_s, sum_s, prod_r[31:1]};
    assign last_s     = (cnt_r == (n_cur_s - 6'd1));

    // Next partial product; the early-exit build realigns on the final step.
    always_comb begin
        step_s = step_raw_s;
`ifdef MUL_EARLY_EXIT_EN
        if (last_s) begin
            step_s = step_raw_s >> (6'd32 - n_cur_s);
        end else begin
            step_s = step_raw_s;
        end
`endif
    end

    // Sequencer next-state and datapath control decode.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        step_en_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_en_s = 1'b1;
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture and per-step partial product / counter update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_r   <= 32'd0;
            prod_r <= 64'd0;
            cnt_r  <= 6'd0;
        end else if (accept_s) begin
            mc_r   <= a;
            prod_r <= {32'd0, b};
            cnt_r  <= 6'd0;
        end else if (step_en_s) begin
            mc_r   <= mc_r;
            prod_r <= step_s;
            cnt_r  <= cnt_r + 6'd1;
        end else begin
            mc_r   <= mc_r;
            prod_r <= prod_r;
            cnt_r  <= cnt_r;
        end
    end

`ifdef MUL_EARLY_EXIT_EN
    // Latch the step count for the accepted multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_r <= 6'd32;
        end else if (accept_s) begin
            n_r <= steps_for(b);
        end else begin
            n_r <= n_r;
        end
    end
`endif

    // Handshake flags registered from the next state, so they never overlap
    // and have no combinational path from start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == ST_RUN);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign p    = prod_r;

endmodule

// -----------------------------------------------------------------------------
// add
//   32-bit ripple-carry adder: s = a + b + cin, carry out on cout.
// -----------------------------------------------------------------------------
module add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    logic [32:0] c_s;

    assign c_s[0] = cin;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ c_s[i];
        assign c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end

    assign cout = c_s[32];

endmodule
